// File: rtl/cdc_event_arbiter.sv
// cdc_event_arbiter: collects single-cycle events from NUM_REQ requesters and
// serialises them onto one req/ack handshake crossing. Each grant issues one
// xfer_req pulse carrying the requester index on xfer_tag, then holds off for
// GUARD_CYCLES so the crossing can finish its round trip before the next one.
module cdc_event_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int GUARD_CYCLES = 16,
  localparam int TAG_W       = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] evt_in,
  input  logic               ovf_clr,
  output logic               xfer_req,
  output logic [TAG_W-1:0]   xfer_tag,
  output logic               busy,
  output logic [NUM_REQ-1:0] pending_out,
  output logic [NUM_REQ-1:0] ovf_out
);

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GUARD = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [TAG_W-1:0]   last_grant;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] ovf;

  logic [TAG_W-1:0]   winner;
  logic               found;
  logic               grant;
  logic [NUM_REQ-1:0] grant_mask;
  logic [NUM_REQ-1:0] ovf_set;
  logic [NUM_REQ-1:0] pending_nxt;

  // Round-robin search: first set pending bit starting just after last_grant.
  // NOTE: every variable driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int               idx;
      logic [TAG_W-1:0] sel;
      idx = (int'(last_grant) + 1 + k) % NUM_REQ;
      sel = TAG_W'(idx);
      if (!found && pending[sel]) begin
        found  = 1'b1;
        winner = sel;
      end
    end
  end

  assign grant = (state == IDLE) && found;

  // Pending/overflow next-state: a grant clears its bit, but a fresh event on
  // the same edge re-arms it without counting as an overflow.
  always_comb begin
    grant_mask = '0;
    if (grant) grant_mask[winner] = 1'b1;
    ovf_set     = evt_in & pending & ~grant_mask;
    pending_nxt = evt_in | (pending & ~grant_mask);
  end

  // Event capture and sticky overflow flags; a set beats a same-edge clear.
  // NOTE: the design holds only flops (no memory arrays), so every state bit is
  // given an async reset value; events in flight at reset are simply dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      ovf     <= '0;
    end else begin
      pending <= pending_nxt;
      ovf     <= (ovf & ~{NUM_REQ{ovf_clr}}) | ovf_set;
    end
  end

  // Issue FSM: IDLE grants, ISSUE pulses xfer_req for one cycle, GUARD waits.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      xfer_req   <= 1'b0;
      xfer_tag   <= '0;
      last_grant <= TAG_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state      <= ISSUE;
            xfer_req   <= 1'b1;
            xfer_tag   <= winner;
            last_grant <= winner;
          end
        end
        ISSUE: begin
          state    <= GUARD;
          xfer_req <= 1'b0;
          cnt      <= CNT_W'(GUARD_CYCLES - 1);
        end
        GUARD: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: begin
          state    <= IDLE;
          xfer_req <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign pending_out = pending;
  assign ovf_out     = ovf;

endmodule

// File: tb/tb_cdc_event_arbiter.sv
// tb_cdc_event_arbiter: table-driven event patterns plus hand-written corner
// sequences; expected grant tags are queued when events are driven and popped
// by a monitor each time xfer_req pulses.
module tb_cdc_event_arbiter;

  localparam int N  = 4;
  localparam int G  = 16;
  localparam int TW = 2;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  evt_in  = '0;
  logic          ovf_clr = 1'b0;
  logic          xfer_req;
  logic [TW-1:0] xfer_tag;
  logic          busy;
  logic [N-1:0]  pending_out;
  logic [N-1:0]  ovf_out;

  cdc_event_arbiter #(.NUM_REQ(N), .GUARD_CYCLES(G)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .evt_in      (evt_in),
    .ovf_clr     (ovf_clr),
    .xfer_req    (xfer_req),
    .xfer_tag    (xfer_tag),
    .busy        (busy),
    .pending_out (pending_out),
    .ovf_out     (ovf_out)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad   = 0;
  logic [TW-1:0] sb[$];
  int            cyc = 0;
  int            pulse_count = 0;

  typedef struct {
    logic [N-1:0] evt;
    int           n;
    logic [7:0]   tags;   // {t3,t2,t1,t0}, t0 granted first
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    evt_in  = '0;
    ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    reset_n = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    check("drain_queue_empty", sb.size(), 0);
    for (int i = 0; i < G + 4 && busy; i++) tick();
    check("drain_idle", busy, 0);
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 10 && !xfer_req; i++) tick();
    check(name, xfer_req, 1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on each pulse, checks width, gap and tag hold.
  initial begin
    bit            have_last = 0;
    logic          prev_req  = 1'b0;
    int            last_pulse = 0;
    logic [TW-1:0] last_tag = '0;
    logic [TW-1:0] exp_tag;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        have_last = 0;
        prev_req  = 1'b0;
      end else begin
        if (xfer_req) begin
          check("pulse_width", prev_req, 0);
          pulse_count++;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: got tag %0d want no pulse (t=%0t)", xfer_tag, $time);
          end else begin
            exp_tag = sb.pop_front();
            check("grant_tag", xfer_tag, exp_tag);
          end
          if (have_last) check("pulse_gap", cyc - last_pulse, G + 2);
          last_pulse = cyc;
          have_last  = 1;
          last_tag   = xfer_tag;
        end else if (have_last) begin
          check("tag_stable", xfer_tag, last_tag);
        end
        prev_req = xfer_req;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cycles;
    int regrants;
    int pc0;

    vecs[0] = '{4'b0001, 1, 8'h00};
    vecs[1] = '{4'b1111, 4, 8'hE4};
    vecs[2] = '{4'b0100, 1, 8'h02};
    vecs[3] = '{4'b1010, 2, 8'h0D};
    vecs[4] = '{4'b1000, 1, 8'h03};
    vecs[5] = '{4'b0110, 2, 8'h09};
    vecs[6] = '{4'b1001, 2, 8'h0C};

    // Reset state, checked while reset is held and after release.
    #2;
    check("rst_req",     xfer_req,    0);
    check("rst_tag",     xfer_tag,    0);
    check("rst_busy",    busy,        0);
    check("rst_pending", pending_out, 0);
    check("rst_ovf",     ovf_out,     0);
    do_reset();
    tick();
    check("post_rst_busy", busy, 0);

    // Single event: timing and busy length.
    do_reset();
    evt_in = 4'b0001;
    sb.push_back(2'd0);
    tick();
    evt_in = '0;
    check("single_capture_pending", pending_out, 4'b0001);
    check("single_capture_req",     xfer_req,    0);
    check("single_capture_busy",    busy,        0);
    tick();
    check("single_issue_req",     xfer_req,    1);
    check("single_issue_tag",     xfer_tag,    0);
    check("single_issue_busy",    busy,        1);
    check("single_issue_pending", pending_out, 0);
    busy_cycles = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy) busy_cycles++;
      else break;
    end
    check("single_busy_cycles", busy_cycles, 17);
    wait_drain(10);

    // Table: one-shot patterns from reset, granted in round-robin order from 0.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      for (int j = 0; j < vecs[v].n; j++) sb.push_back(vecs[v].tags[2*j +: 2]);
      evt_in = vecs[v].evt;
      tick();
      evt_in = '0;
      check("vec_pending", pending_out, vecs[v].evt);
      check("vec_ovf",     ovf_out,     0);
      check("vec_req",     xfer_req,    0);
      wait_drain(vecs[v].n * (G + 2) + 20);
    end

    // Fairness: requesters 0 and 2 re-pulse right after each of their grants.
    do_reset();
    for (int j = 0; j < 3; j++) begin
      sb.push_back(2'd0);
      sb.push_back(2'd2);
    end
    evt_in = 4'b0101;
    tick();
    evt_in = '0;
    regrants = 0;
    for (int c = 0; c < 400 && regrants < 4; c++) begin
      tick();
      if (xfer_req) begin
        evt_in = N'(1) << xfer_tag;
        regrants++;
        tick();
        evt_in = '0;
      end
    end
    check("fair_regrants", regrants, 4);
    wait_drain(4 * (G + 2) + 20);
    check("fair_ovf", ovf_out, 0);

    // Overflow on requester 1, then set-beats-clear on requester 3.
    do_reset();
    pc0 = pulse_count;
    sb.push_back(2'd0);
    sb.push_back(2'd1);
    sb.push_back(2'd3);
    evt_in = 4'b0001;
    tick();
    evt_in = '0;
    wait_req("ovf_first_issue");
    evt_in = 4'b0010;
    tick();
    tick();
    evt_in = '0;
    check("ovf_pending_once", pending_out, 4'b0010);
    check("ovf_set",          ovf_out,     4'b0010);
    evt_in = 4'b1000;
    tick();
    ovf_clr = 1'b1;
    tick();
    evt_in  = '0;
    ovf_clr = 1'b0;
    check("ovf_set_beats_clr", ovf_out,     4'b1000);
    check("ovf_pending_two",   pending_out, 4'b1010);
    check("ovf_busy_guard",    busy,        1);
    wait_drain(3 * (G + 2) + 20);
    repeat (G + 4) tick();
    check("ovf_pulse_count", pulse_count - pc0, 3);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", ovf_out, 0);

    // Reset asserted mid-GUARD with an event pending.
    do_reset();
    sb.push_back(2'd1);
    evt_in = 4'b0010;
    tick();
    evt_in = '0;
    wait_req("rg_issue");
    tick();
    evt_in = 4'b0100;
    tick();
    evt_in = '0;
    tick();
    tick();
    tick();
    check("rg_pending_before", pending_out, 4'b0100);
    check("rg_busy_before",    busy,        1);
    check("rg_tag_before",     xfer_tag,    1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rg_req",     xfer_req,    0);
    check("rg_tag",     xfer_tag,    0);
    check("rg_busy",    busy,        0);
    check("rg_pending", pending_out, 0);
    check("rg_ovf",     ovf_out,     0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    pc0 = pulse_count;
    repeat (3 * G) tick();
    check("rg_no_pulse", pulse_count - pc0, 0);
    check("rg_idle",     busy,              0);

    // Event on the same edge that grants the same requester.
    do_reset();
    sb.push_back(2'd0);
    sb.push_back(2'd0);
    evt_in = 4'b0001;
    tick();
    tick();
    evt_in = '0;
    check("col_req",     xfer_req,       1);
    check("col_tag",     xfer_tag,       0);
    check("col_pending", pending_out[0], 1);
    check("col_ovf",     ovf_out[0],     0);
    wait_drain(2 * (G + 2) + 20);
    check("col_ovf_end", ovf_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdc_event_arbiter.md
CDC_EVENT_ARBITER -- requirements
Module: cdc_event_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of event requesters sharing one handshake crossing; legal range 2..8.
REQ-002 Parameter GUARD_CYCLES, default 16: cycles held after each issue so the crossing can complete its round trip; legal range 2..255.
REQ-003 Port clk  input  1: sole clock; the requester-side clock of the crossing.
REQ-004 Port reset_n  input  1: reset, asynchronous and active-low.
REQ-005 Port evt_in  input  NUM_REQ: per-requester single-cycle event pulses, sampled on every clk rising edge.
REQ-006 Port ovf_clr  input  1: single-cycle pulse that clears all overflow flags.
REQ-007 Port xfer_req  output  1: registered pulse driving the req_in of the handshake crossing.
REQ-008 Port xfer_tag  output  clog2(NUM_REQ): registered index of the granted requester, carried as quasi-static data across the crossing.
REQ-009 Port busy  output  1: high whenever the FSM is not in IDLE.
REQ-010 Port pending_out  output  NUM_REQ: current pending vector.
REQ-011 Port ovf_out  output  NUM_REQ: sticky per-requester overflow flags.

Function
REQ-012 The block SHALL capture each evt_in[i] pulse into pending[i] at the sampling edge.
REQ-013 The FSM SHALL have exactly three states: IDLE, ISSUE and GUARD.
REQ-014 IDLE transitions:
- pending non-zero: go to ISSUE at the next edge.
- on that same edge: load xfer_tag with the round-robin winner and clear pending[winner].
REQ-015 Round-robin arbitration:
- search starts at last_grant+1 (mod NUM_REQ) and takes the first set pending bit.
- last_grant updates to the winner on each grant.
REQ-016 ISSUE SHALL last exactly one cycle with xfer_req=1, then go to GUARD with the counter loaded to GUARD_CYCLES-1.
REQ-017 GUARD SHALL decrement the counter each cycle and go to IDLE on the edge where the counter equals 0, so GUARD lasts GUARD_CYCLES cycles.
REQ-018 xfer_req SHALL be 0 in every state other than ISSUE.
REQ-019 Consecutive xfer_req pulses SHALL be at least GUARD_CYCLES+2 cycles apart.
REQ-020 xfer_tag SHALL change only on the IDLE-to-ISSUE edge, and SHALL hold stable through ISSUE, GUARD and the following IDLE.
REQ-021 Timing: evt_in[i] sampled at edge k while in IDLE with pending empty SHALL produce xfer_req=1 during the cycle after edge k+1.
REQ-022 evt_in[i] on the same edge that clears pending[i] by grant SHALL leave pending[i]=1 and SHALL NOT set ovf[i].
REQ-023 evt_in[i] while pending[i]=1 and not being granted SHALL set ovf[i]; the pending event count stays at one.
REQ-024 ovf_clr SHALL clear all ovf bits; a set on the same edge SHALL win for that bit.
REQ-025 Events SHALL be accepted in every state; only grants are restricted to IDLE.

Reset
REQ-026 Asserting reset_n low at any time, including mid-GUARD, SHALL immediately force:
- state=IDLE, counter=0, xfer_req=0, xfer_tag=0
- pending=0, ovf=0, busy=0
- last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-027 Events in flight at reset SHALL be discarded; after reset deassertion the first grant requires a fresh evt_in pulse.

Verification
REQ-028 Single event: evt_in=0001 at edge k -> xfer_req=1 for one cycle after edge k+1, xfer_tag=0, busy high for 17 cycles (GUARD_CYCLES=16).
REQ-029 Simultaneous events: evt_in=1111 for one cycle -> four pulses with xfer_tag 0,1,2,3, each pulse 18 cycles after the previous one.
REQ-030 Round-robin fairness: requesters 0 and 2 re-pulsed immediately after each grant -> tags alternate 0,2,0,2 with neither starved.
REQ-031 Overflow: evt_in[1] pulsed twice during GUARD with pending[1]=1 -> ovf_out=0010 and only one later grant for tag 1; ovf_clr then gives ovf_out=0000.
REQ-032 Reset during GUARD: reset_n low at GUARD cycle 5 with pending=0100 -> all outputs 0; after release with no evt_in, no xfer_req ever occurs.
REQ-033 Grant/event collision: evt_in[0] pulsed on the edge granting requester 0 -> pending_out[0]=1, ovf_out[0]=0, and a second tag-0 pulse after the guard period.
